// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and opcode-class decode for the
// multi-cycle execute ALU.
package alu_pkg;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_XOR    = 5'd3;
    localparam logic [4:0] ALU_SRL    = 5'd4;
    localparam logic [4:0] ALU_SRA    = 5'd5;
    localparam logic [4:0] ALU_OR     = 5'd6;
    localparam logic [4:0] ALU_AND    = 5'd7;
    localparam logic [4:0] ALU_SLT    = 5'd8;
    localparam logic [4:0] ALU_SLTU   = 5'd9;
    localparam logic [4:0] ALU_MULH   = 5'd16;
    localparam logic [4:0] ALU_MULHSU = 5'd17;
    localparam logic [4:0] ALU_MULHU  = 5'd18;
    localparam logic [4:0] ALU_MUL    = 5'd22;
    localparam logic [4:0] ALU_DIV    = 5'd24;
    localparam logic [4:0] ALU_DIVU   = 5'd26;
    localparam logic [4:0] ALU_REM    = 5'd28;
    localparam logic [4:0] ALU_REMU   = 5'd30;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_mul(input logic [4:0] op);
        return (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU) || (op == ALU_MUL);
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle. The first bit is
// produced on the start edge, so done pulses XLEN-1 cycles after start.
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            done
);

    localparam int CW = $clog2(XLEN + 1);

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] dsr;

    function automatic logic [2*XLEN-1:0] step(input logic [XLEN-1:0] r,
                                               input logic [XLEN-1:0] q,
                                               input logic [XLEN-1:0] d);
        logic [XLEN:0] rs;
        logic [XLEN:0] diff;
        rs   = {r, q[XLEN-1]};
        diff = rs - {1'b0, d};
        if (!diff[XLEN])
            return {diff[XLEN-1:0], q[XLEN-2:0], 1'b1};
        else
            return {rs[XLEN-1:0], q[XLEN-2:0], 1'b0};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            dsr       <= '0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                cnt <= '0;
            end else if (start) begin
                {remainder, quotient} <= step('0, dividend, divisor);
                dsr <= divisor;
                cnt <= CW'(XLEN - 1);
            end else if (cnt != '0) begin
                {remainder, quotient} <= step(remainder, quotient, dsr);
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1))
                    done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle RV32IM/RV64IM execute ALU: single-cycle short ops, pipelined
// multiplier, iterative divider, valid/ready on both sides with flush.
module alu_mc
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      aluop,
    input  logic [XLEN-1:0] aluin1,
    input  logic [XLEN-1:0] aluin2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] aluout,
    output logic            busy
);

    localparam int SW = $clog2(XLEN);
    localparam int CW = $clog2(MUL_STAGES + 1);
    localparam int PW = 2 * XLEN + 2;
    localparam int PD = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
    localparam int PI = (MUL_STAGES > 1) ? MUL_STAGES - 2 : 0;
    localparam logic [CW-1:0] MUL_LOAD = CW'(PI);

    state_t state, state_nx;
    logic                 accept, div_start, div_done;
    logic [4:0]           op_q;
    logic [XLEN-1:0]      a_q, b_q, quo, rem;
    logic [CW-1:0]        mul_cnt;
    logic                 div_first;
    logic signed [PW-1:0] pipe [PD];

    function automatic logic [XLEN-1:0] short_op(input logic [4:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [SW-1:0] sh;
        sh = b[SW-1:0];
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << sh;
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return $signed(a) >>> sh;
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            ALU_SLT:  return {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: return {{(XLEN-1){1'b0}}, a < b};
            default:  return '0;
        endcase
    endfunction

    // One extra bit per operand lets a single signed multiply cover s×s, s×u and u×u.
    function automatic logic signed [PW-1:0] mul_product(input logic [4:0] op,
                                                         input logic [XLEN-1:0] a,
                                                         input logic [XLEN-1:0] b);
        logic signed [XLEN:0] ma, mb;
        ma = {(op != ALU_MULHU) & a[XLEN-1], a};
        mb = {((op == ALU_MULH) || (op == ALU_MUL)) & b[XLEN-1], b};
        return ma * mb;
    endfunction

    function automatic logic [XLEN-1:0] mul_sel(input logic [4:0] op,
                                                input logic signed [PW-1:0] p);
        return (op == ALU_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    function automatic state_t op_target(input logic [4:0] op);
        if (is_mul(op))
            return (MUL_STAGES == 1) ? ST_DONE : ST_MUL;
        else if (is_div(op))
            return ST_DIV;
        else
            return ST_DONE;
    endfunction

    // Divide operand conditioning and result sign fix-up.
    logic            div_signed, div_is_rem, neg_a, neg_b, div_zero, div_ovf, special;
    logic [XLEN-1:0] mag_a, mag_b, special_res, fixed_res;

    assign div_signed  = (op_q == ALU_DIV) || (op_q == ALU_REM);
    assign div_is_rem  = (op_q == ALU_REM) || (op_q == ALU_REMU);
    assign neg_a       = div_signed & a_q[XLEN-1];
    assign neg_b       = div_signed & b_q[XLEN-1];
    assign mag_a       = neg_a ? -a_q : a_q;
    assign mag_b       = neg_b ? -b_q : b_q;
    assign div_zero    = (b_q == '0);
    assign div_ovf     = div_signed && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
    assign special     = div_zero || div_ovf;
    assign special_res = div_zero ? (div_is_rem ? a_q : '1) : (div_is_rem ? '0 : a_q);
    assign fixed_res   = div_is_rem ? (neg_a ? -rem : rem) : ((neg_a ^ neg_b) ? -quo : quo);

    div_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .abort     (flush),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (quo),
        .remainder (rem),
        .done      (div_done)
    );

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept) state_nx = op_target(aluop);
                ST_MUL:  if (mul_cnt == '0) state_nx = ST_DONE;
                ST_DIV: begin
                    if (div_first) begin
                        if (special) state_nx = ST_DONE;
                    end else if (div_done) begin
                        state_nx = ST_DONE;
                    end
                end
                ST_DONE: if (out_ready) state_nx = accept ? op_target(aluop) : ST_IDLE;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = !flush && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
        out_valid = (state == ST_DONE);
        busy      = (state != ST_IDLE);
        div_start = (state == ST_DIV) && div_first && !special && !flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mul_cnt   <= '0;
            div_first <= 1'b0;
            aluout    <= '0;
            for (int i = 0; i < PD; i++) pipe[i] <= '0;
        end else begin
            if (accept) begin
                op_q      <= aluop;
                a_q       <= aluin1;
                b_q       <= aluin2;
                mul_cnt   <= MUL_LOAD;
                div_first <= is_div(aluop);
                pipe[0]   <= mul_product(aluop, aluin1, aluin2);
                if (!is_mul(aluop) && !is_div(aluop))
                    aluout <= short_op(aluop, aluin1, aluin2);
                else if (is_mul(aluop) && (MUL_STAGES == 1))
                    aluout <= mul_sel(aluop, mul_product(aluop, aluin1, aluin2));
            end else begin
                div_first <= 1'b0;
                if ((state == ST_MUL) && (mul_cnt != '0))
                    mul_cnt <= mul_cnt - 1'b1;
                if ((state == ST_MUL) && (mul_cnt == '0))
                    aluout <= mul_sel(op_q, pipe[PI]);
                if ((state == ST_DIV) && div_first && special)
                    aluout <= special_res;
                if ((state == ST_DIV) && !div_first && div_done)
                    aluout <= fixed_res;
            end
            for (int i = 1; i < PD; i++) pipe[i] <= pipe[i-1];
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc: a driver issues ops and queues expected
// results and latencies; a negedge monitor checks them as results are taken.
module tb_alu_mc;

    localparam int XLEN = 32;
    localparam int MS   = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            flush = 1'b0;
    logic            out_ready = 1'b1;
    logic [4:0]      aluop = '0;
    logic [XLEN-1:0] aluin1 = '0;
    logic [XLEN-1:0] aluin2 = '0;
    logic            in_ready, out_valid, busy;
    logic [XLEN-1:0] aluout;

    alu_mc #(.XLEN(XLEN), .MUL_STAGES(MS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .aluin1    (aluin1),
        .aluin2    (aluin2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .aluout    (aluout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [XLEN-1:0] exp_q[$];
    int              lat_q[$];
    int              acc_q[$];
    int              n_checks = 0;
    int              n_fail = 0;
    logic            seen = 1'b0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input logic [4:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] e, input int lat, output int waited);
        int n;
        n = 0;
        in_valid = 1'b1;
        aluop    = op;
        aluin1   = a;
        aluin2   = b;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: op %0d not accepted within 200 cycles", op);
        end else begin
            exp_q.push_back(e);
            lat_q.push_back(lat);
            acc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
        end
    endtask

    // Monitor: latency on first sight of a result, hold stability, data on handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got 0x%08h, expected no result", aluout);
            end else begin
                if (!seen) begin
                    check("latency", XLEN'(cyc - acc_q[0]), XLEN'(lat_q[0]));
                    seen = 1'b1;
                end
                if (!out_ready) begin
                    check("hold_aluout", aluout, exp_q[0]);
                    check("hold_in_ready", XLEN'(in_ready), '0);
                end else begin
                    check("result", aluout, exp_q[0]);
                    void'(exp_q.pop_front());
                    void'(lat_q.pop_front());
                    void'(acc_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        int   w;
        logic saw;
        #1;
        check("rst_in_ready", XLEN'(in_ready), 1);
        check("rst_out_valid", XLEN'(out_valid), 0);
        check("rst_busy", XLEN'(busy), 0);
        check("rst_aluout", aluout, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back short ops
        issue(5'd0, 32'd5, 32'd7, 32'h0000000C, 1, w);
        issue(5'd1, 32'd3, 32'd5, 32'hFFFFFFFE, 1, w);
        check("b2b_in_ready", XLEN'(w), 0);
        issue(5'd5, 32'h80000000, 32'h24, 32'hF8000000, 1, w);
        issue(5'd2, 32'h1, 32'h21, 32'h00000002, 1, w);
        issue(5'd9, 32'h1, 32'hFFFFFFFF, 32'h00000001, 1, w);
        issue(5'd8, 32'hFFFFFFFF, 32'h1, 32'h00000001, 1, w);
        issue(5'd10, 32'h1234, 32'h5678, 32'h00000000, 1, w);
        wait_idle();

        // Multiplies
        issue(5'd22, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, MS, w);
        issue(5'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MS, w);
        issue(5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MS, w);
        issue(5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MS, w);
        wait_idle();

        // Divides, including the bypassed special cases
        issue(5'd24, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, XLEN + 2, w);
        issue(5'd28, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, XLEN + 2, w);
        issue(5'd26, 32'd100, 32'd7, 32'd14, XLEN + 2, w);
        issue(5'd30, 32'd100, 32'd7, 32'd2, XLEN + 2, w);
        issue(5'd26, 32'd9, 32'd0, 32'hFFFFFFFF, 2, w);
        issue(5'd30, 32'd9, 32'd0, 32'd9, 2, w);
        issue(5'd24, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, w);
        issue(5'd28, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2, w);
        wait_idle();

        // Consumer stall, then release with a new op in the same cycle
        out_ready = 1'b0;
        issue(5'd3, 32'hF0, 32'h0F, 32'hFF, 1, w);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(5'd7, 32'h7, 32'h3, 32'h3, 1, w);
        check("same_cycle_accept", XLEN'(w), 0);
        wait_idle();

        // Flush mid-divide
        issue(5'd26, 32'd100, 32'd3, 32'd33, XLEN + 2, w);
        repeat (9) @(posedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        aluop    = 5'd0;
        aluin1   = 32'd5;
        aluin2   = 32'd5;
        @(negedge clk);
        check("flush_in_ready", XLEN'(in_ready), 0);
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_flush_in_ready", XLEN'(in_ready), 1);
        check("post_flush_busy", XLEN'(busy), 0);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        check("flush_no_result", XLEN'(saw), 0);
        @(posedge clk);
        #1;
        issue(5'd0, 32'd1, 32'd1, 32'd2, 1, w);
        wait_idle();

        // Asynchronous reset during a multiply
        issue(5'd22, 32'd3, 32'd4, 32'd12, MS, w);
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        check("mul_busy", XLEN'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", XLEN'(in_ready), 1);
        check("arst_out_valid", XLEN'(out_valid), 0);
        check("arst_busy", XLEN'(busy), 0);
        check("arst_aluout", aluout, '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        @(posedge clk);
        #1;
        issue(5'd6, 32'h0F00, 32'h00F0, 32'h0FF0, 1, w);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
